// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks.
package fifo_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_PTR_SIZE   = 4;
    localparam int MEM_RD_LATENCY     = 1;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] fifo_data_t;
endpackage

// File: rtl/rd_skid_buf.sv
// Circular prefetch buffer holding words returned by the FIFO memory.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 3,
    localparam int IDX_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [IDX_W-1:0]      head;
    logic [IDX_W-1:0]      tail;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                buf_mem[tail] <= push_data;
                tail          <= next_idx(tail);
            end
            if (pop) begin
                head <= next_idx(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = buf_mem[head];

endmodule

// File: rtl/rd_stream_adapter.sv
// Async FIFO read-port consumer: prefetches words and presents them as a valid/ready stream.
// Optional beat counter output rd_count is enabled with RD_STREAM_CNT_EN.
module rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef RD_STREAM_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    if (BUF_DEPTH < 2 || BUF_DEPTH > 8 || CNT_WIDTH < 1 || MEM_RD_LATENCY != 1) begin : g_bad_param
        $error("rd_stream_adapter: unsupported parameter set");
    end

    logic             inflight;
    logic             pop;
    logic [CNT_W-1:0] count;

    // Issue decision uses only registered occupancy so m_ready never reaches r_en.
    assign r_en    = !empty &&
                     ((CNT_W+1)'(count) + (CNT_W+1)'(inflight) < (CNT_W+1)'(BUF_DEPTH));
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= r_en;
        end
    end

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid_buf (
        .r_clk     (r_clk),
        .rrst_n    (rrst_n),
        .push      (inflight),
        .push_data (fifo_rdata),
        .pop       (pop),
        .count     (count),
        .head_data (m_data)
    );

`ifdef RD_STREAM_CNT_EN
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
